// File: rtl/tick_scheduler_if.sv
// Configuration write port of the tick scheduler: a valid/ready handshake
// that carries a target channel and its new period, mode and enable.
interface tick_scheduler_if #(
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 12
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_mode;
    logic                cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_mode, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_mode, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: a free-running prescaler emits a base tick,
// after which a shared scan walks every channel once, decrementing its count
// and producing expiry pulses / toggling levels in channel-index order.

// One timer channel: holds period/count/mode/armed state and reacts to a
// config write strobe or a service strobe from the scan.
module tick_scheduler_ch #(
    parameter int PERIOD_W = 12
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic                wr_mode,
    input  logic                wr_en,
    input  logic                svc,
    output logic                pulse,
    output logic                level,
    output logic                active
);
    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] count;
    logic                mode;

    // Channel state: a write restarts the channel; a service either expires it or counts down.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period <= '0;
            count  <= '0;
            mode   <= 1'b0;
            active <= 1'b0;
            pulse  <= 1'b0;
            level  <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (wr) begin
                period <= wr_period;
                count  <= wr_period;
                mode   <= wr_mode;
                active <= wr_en && (wr_period != '0);
                level  <= 1'b0;
            end else if (svc && active) begin
                if (count == ONE) begin
                    pulse <= 1'b1;
                    level <= ~level;
                    if (mode) begin
                        // One-shot: disarm in the same cycle the pulse is raised.
                        active <= 1'b0;
                        count  <= '0;
                    end else begin
                        count <= period;
                    end
                end else if (count > ONE) begin
                    // Never decrement below 1, so the count cannot wrap.
                    count <= count - ONE;
                end
            end
        end
    end
endmodule

module tick_scheduler #(
    parameter int TICK_DIV = 100_000,
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    tick_scheduler_if.slave   cfg,
    output logic              base_tick,
    output logic [NUM_CH-1:0] ch_pulse,
    output logic [NUM_CH-1:0] ch_level,
    output logic [NUM_CH-1:0] ch_active
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PS_W = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] PS_PRE  = PS_W'(TICK_DIV - 2);
    localparam logic [CH_W-1:0] IDX_LAST = CH_W'(NUM_CH - 1);

    // The whole scan must fit between two ticks, with at least one idle cycle left.
    if (TICK_DIV < NUM_CH + 2) begin : g_bad_div
        $error("tick_scheduler: TICK_DIV must be >= NUM_CH+2");
    end
    if (NUM_CH < 2) begin : g_bad_ch
        $error("tick_scheduler: NUM_CH must be >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   idx, idx_nxt;
    logic [PS_W-1:0]   presc;
    logic              scanning;
    logic              ready;
    logic [NUM_CH-1:0] svc;
    logic [NUM_CH-1:0] wr;

    // Free-running prescaler; base_tick is registered so it is high exactly
    // while the prescaler holds its terminal value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc     <= '0;
            base_tick <= 1'b0;
        end else begin
            presc     <= (presc == PS_LAST) ? '0 : presc + 1'b1;
            base_tick <= (presc == PS_PRE);
        end
    end

    // Scan FSM state and channel index registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Scan FSM next state: a tick starts a scan of one channel per cycle.
    // Ready is gated by reset so the port reads not-ready while held in reset.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        scanning  = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = resetn && !base_tick;
                if (base_tick) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                scanning = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign cfg.cfg_ready = ready;

    // Per-channel strobes; an out-of-range channel index decodes to no
    // channel, so the handshake still completes without touching state.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign svc[c] = scanning && (idx == CH_W'(c));
        assign wr[c]  = cfg.cfg_valid && ready && (cfg.cfg_ch == CH_W'(c));

        tick_scheduler_ch #(
            .PERIOD_W (PERIOD_W)
        ) u_ch (
            .clk       (clk),
            .resetn    (resetn),
            .wr        (wr[c]),
            .wr_period (cfg.cfg_period),
            .wr_mode   (cfg.cfg_mode),
            .wr_en     (cfg.cfg_en),
            .svc       (svc[c]),
            .pulse     (ch_pulse[c]),
            .level     (ch_level[c]),
            .active    (ch_active[c])
        );
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: a tick-level model predicts base_tick, ready and
// per-channel pulse/level/active every cycle; directed scenarios pin the model
// with hand-computed cycle numbers, then random config traffic follows.
module tb_tick_scheduler;
    localparam int TD = 8;
    localparam int NC = 4;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tick_scheduler_if #(.NUM_CH(NC), .PERIOD_W(PW)) cfg ();
    logic          base_tick;
    logic [NC-1:0] ch_pulse, ch_level, ch_active;

    tick_scheduler #(.TICK_DIV(TD), .NUM_CH(NC), .PERIOD_W(PW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cfg       (cfg),
        .base_tick (base_tick),
        .ch_pulse  (ch_pulse),
        .ch_level  (ch_level),
        .ch_active (ch_active)
    );

    // Second instance with a non-power-of-two channel count, so an
    // out-of-range channel index can actually be driven.
    tick_scheduler_if #(.NUM_CH(3), .PERIOD_W(PW)) cfg3 ();
    logic       base_tick3;
    logic [2:0] ch_pulse3, ch_level3, ch_active3;

    tick_scheduler #(.TICK_DIV(TD), .NUM_CH(3), .PERIOD_W(PW)) dut3 (
        .clk       (clk),
        .resetn    (resetn),
        .cfg       (cfg3),
        .base_tick (base_tick3),
        .ch_pulse  (ch_pulse3),
        .ch_level  (ch_level3),
        .ch_active (ch_active3)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (tick-level) ----------------
    int cyc, last_tick;
    int m_per[NC], m_rem[NC], pulse_at[NC];
    bit m_mode[NC], m_arm[NC], fall_at[NC], v_level[NC], v_active[NC];
    bit exp_tick, exp_rdy;
    logic [NC-1:0] ep, el, ea;
    int plog[$];
    int tick_log[$];
    bit rdy_hist[4096];
    int p3cnt;

    task model_reset();
        cyc = 0;
        last_tick = -100;
        for (int i = 0; i < NC; i++) begin
            m_per[i] = 0; m_rem[i] = 0; pulse_at[i] = -1;
            m_mode[i] = 0; m_arm[i] = 0; fall_at[i] = 0;
            v_level[i] = 0; v_active[i] = 0;
        end
    endtask

    // Compare process: checks every cycle, then advances the model with this cycle's inputs.
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_base_tick", int'(base_tick), 0);
            chk("rst_pulse", int'(ch_pulse), 0);
            chk("rst_level", int'(ch_level), 0);
            chk("rst_active", int'(ch_active), 0);
            chk("rst_ready", int'(cfg.cfg_ready), 0);
            model_reset();
        end else begin
            exp_tick = (cyc % TD == TD - 1);
            if (exp_tick) last_tick = cyc;
            exp_rdy = !(cyc - last_tick <= NC);
            for (int i = 0; i < NC; i++) begin
                ep[i] = (pulse_at[i] == cyc);
                if (ep[i]) begin
                    v_level[i] = !v_level[i];
                    if (fall_at[i]) v_active[i] = 0;
                    pulse_at[i] = -1;
                end
                el[i] = v_level[i];
                ea[i] = v_active[i];
            end
            chk("base_tick", int'(base_tick), int'(exp_tick));
            chk("cfg_ready", int'(cfg.cfg_ready), int'(exp_rdy));
            chk("ch_pulse", int'(ch_pulse), int'(ep));
            chk("ch_level", int'(ch_level), int'(el));
            chk("ch_active", int'(ch_active), int'(ea));

            if (base_tick) tick_log.push_back(cyc);
            for (int i = 0; i < NC; i++) if (ch_pulse[i]) plog.push_back(cyc * 8 + i);
            if (cyc < 4096) rdy_hist[cyc] = cfg.cfg_ready;
            if (ch_pulse3 != 0) p3cnt++;

            if (cfg.cfg_valid && exp_rdy && int'(cfg.cfg_ch) < NC) begin
                int c;
                c = int'(cfg.cfg_ch);
                m_per[c]    = int'(cfg.cfg_period);
                m_rem[c]    = int'(cfg.cfg_period);
                m_mode[c]   = cfg.cfg_mode;
                m_arm[c]    = cfg.cfg_en && (cfg.cfg_period != 0);
                v_active[c] = m_arm[c];
                v_level[c]  = 0;
                pulse_at[c] = -1;
            end
            if (exp_tick) begin
                for (int i = 0; i < NC; i++) begin
                    if (m_arm[i]) begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin
                            pulse_at[i] = cyc + 2 + i;
                            fall_at[i]  = m_mode[i];
                            if (m_mode[i]) m_arm[i] = 0;
                            else m_rem[i] = m_per[i];
                        end
                    end
                end
            end
            cyc++;
        end
    end

    function automatic int nth(int ch, int n);
        int k = 0;
        foreach (plog[j]) if (plog[j] % 8 == ch) begin
            if (k == n) return plog[j] / 8;
            k++;
        end
        return -1;
    endfunction

    function automatic int cnt(int ch, int upto);
        int k = 0;
        foreach (plog[j]) if (plog[j] % 8 == ch && plog[j] / 8 < upto) k++;
        return k;
    endfunction

    // ---------------- driver ----------------
    int dcyc;

    task automatic step();
        @(posedge clk);
        #2;
        dcyc++;
    endtask

    task automatic wait_to(int c);
        while (dcyc < c) step();
    endtask

    task automatic write_cfg(int ch, int p, bit mode, bit en);
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_ch     = 2'(ch);
        cfg.cfg_period = 4'(p);
        cfg.cfg_mode   = mode;
        cfg.cfg_en     = en;
        for (int k = 0; k < 20; k++) begin
            if (cfg.cfg_ready) begin
                step();
                cfg.cfg_valid = 1'b0;
                return;
            end
            step();
        end
        cfg.cfg_valid = 1'b0;
        chk("write_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, lows;
        cfg.cfg_valid = 0; cfg.cfg_ch = 0; cfg.cfg_period = 0; cfg.cfg_mode = 0; cfg.cfg_en = 0;
        cfg3.cfg_valid = 0; cfg3.cfg_ch = 0; cfg3.cfg_period = 0; cfg3.cfg_mode = 0; cfg3.cfg_en = 0;
        p3cnt = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        dcyc = 0;

        // Periodic ch0, P=3, written in cycle 1.
        step();
        write_cfg(0, 3, 1'b0, 1'b1);
        wait_to(76);
        chk("tick_first", tick_log.size() > 0 ? tick_log[0] : -1, 7);
        chk("tick_second", tick_log.size() > 1 ? tick_log[1] : -1, 15);
        chk("tick_third", tick_log.size() > 2 ? tick_log[2] : -1, 23);
        chk("ch0_pulse1", nth(0, 0), 25);
        chk("ch0_pulse2", nth(0, 1), 49);
        chk("ch0_pulse3", nth(0, 2), 73);

        // One-shot ch2, P=2, written at 77: ticks 79, 87 -> pulse 91 only.
        wait_to(77);
        write_cfg(2, 2, 1'b1, 1'b1);
        wait_to(140);
        chk("ch2_oneshot_at", nth(2, 0), 91);
        chk("ch2_oneshot_count", cnt(2, 140), 1);

        // Valid raised in tick cycle 143 and held; commits once at 148.
        wait_to(143);
        cfg.cfg_valid = 1; cfg.cfg_ch = 2'd1; cfg.cfg_period = 4'd5; cfg.cfg_mode = 0; cfg.cfg_en = 1;
        repeat (6) step();
        cfg.cfg_valid = 0;
        lows = 0;
        for (int c = 143; c <= 147; c++) if (!rdy_hist[c]) lows++;
        chk("ready_low_cycles", lows, 5);
        chk("ready_at_148", int'(rdy_hist[148]), 1);

        // Rewrite ch1 after 3 ticks: restart to 5 ticks -> pulse at 210, not 186.
        wait_to(172);
        write_cfg(1, 5, 1'b0, 1'b1);
        write_cfg(3, 0, 1'b0, 1'b1);
        wait_to(215);
        chk("ch1_restart_first", nth(1, 0), 210);
        chk("ch1_none_before", cnt(1, 210), 0);
        chk("ch3_p0_inactive", int'(ch_active[3]), 0);

        // Out-of-range channel on the 3-channel instance: accepted, no effect.
        wait_to(220);
        cfg3.cfg_valid = 1; cfg3.cfg_ch = 2'd3; cfg3.cfg_period = 4'd1; cfg3.cfg_mode = 0; cfg3.cfg_en = 1;
        chk("inv_ch_ready", int'(cfg3.cfg_ready), 1);
        step();
        cfg3.cfg_valid = 0;
        wait_to(245);
        chk("inv_ch_active", int'(ch_active3), 0);
        chk("inv_ch_pulses", p3cnt, 0);
        wait_to(252);
        cfg3.cfg_valid = 1; cfg3.cfg_ch = 2'd2;
        step();
        cfg3.cfg_valid = 0;
        chk("ch3x_valid_active", int'(ch_active3), 4);
        wait_to(262);
        chk("ch3x_valid_pulses", p3cnt, 1);

        // Random config traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            cfg.cfg_valid  = ($urandom % 3 == 0);
            cfg.cfg_ch     = 2'($urandom % 4);
            cfg.cfg_period = ($urandom % 2 == 1) ? 4'($urandom_range(1, 3)) : 4'($urandom % 16);
            cfg.cfg_mode   = 1'($urandom % 2);
            cfg.cfg_en     = ($urandom % 4 != 0);
            step();
        end
        cfg.cfg_valid = 0;

        // All channels P=1: pulses at T+2..T+5; reset at T+3 on the next tick.
        for (int i = 0; i < NC; i++) write_cfg(i, 1, 1'b0, 1'b1);
        for (int k = 0; k < 16 && dcyc % TD != TD - 1; k++) step();
        t0 = dcyc;
        plog.delete();
        repeat (6) step();
        for (int i = 0; i < NC; i++) chk($sformatf("all_p1_ch%0d", i), nth(i, 0), t0 + 2 + i);
        for (int k = 0; k < 16 && dcyc % TD != TD - 1; k++) step();
        repeat (3) step();
        resetn = 1'b0;
        #1;
        chk("async_rst_pulse", int'(ch_pulse), 0);
        chk("async_rst_active", int'(ch_active), 0);
        repeat (2) step();
        plog.delete();
        resetn = 1'b1;
        dcyc = 0;
        repeat (40) step();
        chk("no_pulse_after_rst", plog.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
